// File: rtl/systolic_array_os_if.sv
// Stream and control bundle for systolic_array_os: run control, input beat stream,
// row-by-row result stream and status.
interface systolic_array_os_if #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int BW_ACT = 8,
  parameter int BW_WET = 8,
  parameter int BW_OUT = 8,
  parameter int BW_K   = 8
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic                     start;
  logic [BW_K-1:0]          k_len;
  logic [5:0]               shift_num;
  logic                     in_valid;
  logic                     in_ready;
  logic [ROWS*BW_ACT-1:0]   act_in;
  logic [COLS*BW_WET-1:0]   wet_in;
  logic                     out_valid;
  logic                     out_ready;
  logic [COLS*BW_OUT-1:0]   out_data;
  logic [RW-1:0]            out_row;
  logic                     busy;
  logic                     done;

  modport master (
    output start, k_len, shift_num, in_valid, act_in, wet_in, out_ready,
    input  in_ready, out_valid, out_data, out_row, busy, done
  );

  modport slave (
    input  start, k_len, shift_num, in_valid, act_in, wet_in, out_ready,
    output in_ready, out_valid, out_data, out_row, busy, done
  );
endinterface

// File: rtl/systolic_array_os.sv
// Output-stationary ROWS x COLS signed MAC array with skewed operand entry and a
// requantised row stream. Define SYSTOLIC_RELU_EN to clamp negative results to zero.
//
// state  | meaning
// IDLE   | waiting for start with non-zero k_len
// FEED   | accepting k_len input beats
// DRAIN  | operands still travelling through the array
// OUTPUT | presenting one requantised row per handshake
module systolic_array_os #(
  parameter int ROWS    = 4,
  parameter int COLS    = 4,
  parameter int BW_ACT  = 8,
  parameter int BW_WET  = 8,
  parameter int BW_ACCU = 32,
  parameter int BW_OUT  = 8,
  parameter int BW_K    = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  systolic_array_os_if.slave bus
);
  localparam int RW      = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int BW_PROD = BW_ACT + BW_WET;
  localparam int DW      = $clog2(ROWS + COLS) + 1;
  localparam logic [DW-1:0] DRAIN_LEN = DW'(ROWS + COLS - 1);
  localparam logic signed [BW_ACCU-1:0] SAT_MAX = BW_ACCU'((2 ** (BW_OUT - 1)) - 1);
  localparam logic signed [BW_ACCU-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, OUTPUT} state_t;

  state_t                 state;
  logic [BW_K-1:0]        beats_left;
  logic [DW-1:0]          drain_cnt;
  logic [5:0]             shift_q;
  logic                   in_ready_q, out_valid_q, busy_q, done_q;
  logic [COLS*BW_OUT-1:0] out_data_q;
  logic [RW-1:0]          out_row_q;

  logic accept, run_start, out_fire;
  assign accept    = bus.in_valid & in_ready_q;
  assign run_start = (state == IDLE) & bus.start & (bus.k_len != '0);
  assign out_fire  = out_valid_q & bus.out_ready;

  logic signed [BW_ACT-1:0]  a_sk [ROWS][ROWS];
  logic                      av_sk[ROWS][ROWS];
  logic signed [BW_WET-1:0]  b_sk [COLS][COLS];
  logic                      bv_sk[COLS][COLS];
  logic signed [BW_ACT-1:0]  a_q  [ROWS][COLS];
  logic                      av_q [ROWS][COLS];
  logic signed [BW_WET-1:0]  b_q  [ROWS][COLS];
  logic                      bv_q [ROWS][COLS];
  logic signed [BW_ACCU-1:0] acc  [ROWS][COLS];

  logic signed [BW_ACT-1:0]  a_in [ROWS][COLS];
  logic                      av_in[ROWS][COLS];
  logic signed [BW_WET-1:0]  b_in [ROWS][COLS];
  logic                      bv_in[ROWS][COLS];
  logic signed [BW_PROD-1:0] prod [ROWS][COLS];

  // Row r / column c operands see r / c skew stages before the array edge.
  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (c == 0) begin
          if (r == 0) begin
            a_in[r][c]  = bus.act_in[r*BW_ACT +: BW_ACT];
            av_in[r][c] = accept;
          end else begin
            a_in[r][c]  = a_sk[r][(r > 0) ? r - 1 : 0];
            av_in[r][c] = av_sk[r][(r > 0) ? r - 1 : 0];
          end
        end else begin
          a_in[r][c]  = a_q[r][(c > 0) ? c - 1 : 0];
          av_in[r][c] = av_q[r][(c > 0) ? c - 1 : 0];
        end
        if (r == 0) begin
          if (c == 0) begin
            b_in[r][c]  = bus.wet_in[c*BW_WET +: BW_WET];
            bv_in[r][c] = accept;
          end else begin
            b_in[r][c]  = b_sk[c][(c > 0) ? c - 1 : 0];
            bv_in[r][c] = bv_sk[c][(c > 0) ? c - 1 : 0];
          end
        end else begin
          b_in[r][c]  = b_q[(r > 0) ? r - 1 : 0][c];
          bv_in[r][c] = bv_q[(r > 0) ? r - 1 : 0][c];
        end
        prod[r][c] = BW_PROD'(a_in[r][c]) * BW_PROD'(b_in[r][c]);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < ROWS; r++)
        for (int d = 0; d < ROWS; d++) begin
          a_sk[r][d]  <= '0;
          av_sk[r][d] <= 1'b0;
        end
      for (int c = 0; c < COLS; c++)
        for (int d = 0; d < COLS; d++) begin
          b_sk[c][d]  <= '0;
          bv_sk[c][d] <= 1'b0;
        end
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) begin
          a_q[r][c]  <= '0;
          av_q[r][c] <= 1'b0;
          b_q[r][c]  <= '0;
          bv_q[r][c] <= 1'b0;
          acc[r][c]  <= '0;
        end
    end else begin
      for (int r = 0; r < ROWS; r++) begin
        a_sk[r][0]  <= bus.act_in[r*BW_ACT +: BW_ACT];
        av_sk[r][0] <= accept;
        for (int d = 1; d < ROWS; d++) begin
          a_sk[r][d]  <= a_sk[r][d-1];
          av_sk[r][d] <= av_sk[r][d-1];
        end
      end
      for (int c = 0; c < COLS; c++) begin
        b_sk[c][0]  <= bus.wet_in[c*BW_WET +: BW_WET];
        bv_sk[c][0] <= accept;
        for (int d = 1; d < COLS; d++) begin
          b_sk[c][d]  <= b_sk[c][d-1];
          bv_sk[c][d] <= bv_sk[c][d-1];
        end
      end
      // Accumulate only on paired valid operands so input bubbles leave results unchanged.
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) begin
          a_q[r][c]  <= a_in[r][c];
          av_q[r][c] <= av_in[r][c];
          b_q[r][c]  <= b_in[r][c];
          bv_q[r][c] <= bv_in[r][c];
          if (run_start)
            acc[r][c] <= '0;
          else if (av_in[r][c] && bv_in[r][c])
            acc[r][c] <= acc[r][c] + BW_ACCU'(prod[r][c]);
        end
    end
  end

  function automatic logic [BW_OUT-1:0] requant(input logic signed [BW_ACCU-1:0] v,
                                                input logic [5:0] sh);
    logic signed [BW_ACCU-1:0] s;
    logic [5:0]                sh_eff;
    sh_eff = (32'(sh) >= BW_ACCU) ? 6'(BW_ACCU - 1) : sh;
    s = v >>> sh_eff;
    if (s > SAT_MAX)
      s = SAT_MAX;
    else if (s < SAT_MIN)
      s = SAT_MIN;
`ifdef SYSTOLIC_RELU_EN
    if (s[BW_ACCU-1])
      s = '0;
`endif
    return s[BW_OUT-1:0];
  endfunction

  logic [RW-1:0]          row_sel;
  logic [COLS*BW_OUT-1:0] row_data;

  always_comb begin
    row_sel = '0;
    if (state == OUTPUT && out_row_q != RW'(ROWS - 1))
      row_sel = out_row_q + RW'(1);
    row_data = '0;
    for (int c = 0; c < COLS; c++)
      row_data[c*BW_OUT +: BW_OUT] = requant(acc[row_sel][c], shift_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      beats_left  <= '0;
      drain_cnt   <= '0;
      shift_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_row_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (run_start) begin
            beats_left <= bus.k_len;
            shift_q    <= bus.shift_num;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            state      <= FEED;
          end
        end
        FEED: begin
          if (accept) begin
            beats_left <= beats_left - BW_K'(1);
            if (beats_left == BW_K'(1)) begin
              in_ready_q <= 1'b0;
              drain_cnt  <= DRAIN_LEN;
              state      <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) begin
            out_valid_q <= 1'b1;
            out_row_q   <= '0;
            out_data_q  <= row_data;
            state       <= OUTPUT;
          end else begin
            drain_cnt <= drain_cnt - DW'(1);
          end
        end
        OUTPUT: begin
          if (out_fire) begin
            if (out_row_q == RW'(ROWS - 1)) begin
              out_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              state       <= IDLE;
            end else begin
              out_row_q  <= out_row_q + RW'(1);
              out_data_q <= row_data;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_row   = out_row_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_systolic_array_os.sv
// Randomised scoreboard bench for systolic_array_os: expected rows come from a plain
// matrix-multiply reference and are compared by an independent output monitor.
module tb_systolic_array_os;
  localparam int ROWS = 4, COLS = 4, BW_ACT = 8, BW_WET = 8, BW_ACCU = 32;
  localparam int BW_OUT = 8, BW_K = 8, MAXK = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  systolic_array_os_if #(.ROWS(ROWS), .COLS(COLS), .BW_ACT(BW_ACT), .BW_WET(BW_WET),
                         .BW_OUT(BW_OUT), .BW_K(BW_K)) bus ();

  systolic_array_os #(.ROWS(ROWS), .COLS(COLS), .BW_ACT(BW_ACT), .BW_WET(BW_WET),
                      .BW_ACCU(BW_ACCU), .BW_OUT(BW_OUT), .BW_K(BW_K))
    dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  typedef struct { int row; logic [COLS*BW_OUT-1:0] data; } exp_t;
  exp_t exp_q[$];
  exp_t e_pop;

  int checks = 0, errors = 0, cyc = 0, done_cnt = 0, first_ov = -1, last_row = -1;
  bit ov_prev = 1'b0, rand_ready = 1'b0;
  int a_mat[MAXK][ROWS];
  int b_mat[MAXK][COLS];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic logic [BW_OUT-1:0] model(input int r, input int c, input int k, input int sh);
    logic signed [31:0] sum;
    logic signed [31:0] v;
    int s;
    sum = 0;
    for (int i = 0; i < k; i++) sum += a_mat[i][r] * b_mat[i][c];
    s = (sh > BW_ACCU - 1) ? BW_ACCU - 1 : sh;
    v = sum >>> s;
    if (v > (1 << (BW_OUT - 1)) - 1) v = (1 << (BW_OUT - 1)) - 1;
    else if (v < -(1 << (BW_OUT - 1))) v = -(1 << (BW_OUT - 1));
`ifdef SYSTOLIC_RELU_EN
    if (v < 0) v = 0;
`endif
    return v[BW_OUT-1:0];
  endfunction

  function automatic logic [COLS*BW_OUT-1:0] model_row(input int r, input int k, input int sh);
    logic [COLS*BW_OUT-1:0] d;
    d = '0;
    for (int c = 0; c < COLS; c++) d[c*BW_OUT +: BW_OUT] = model(r, c, k, sh);
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Output monitor: pops the scoreboard on every row handshake.
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.out_valid && !ov_prev && first_ov < 0) first_ov = cyc;
      ov_prev = bus.out_valid;
      if (bus.done) begin
        done_cnt++;
        chk("done_after_last_row", longint'(exp_q.size() == 0 && last_row == ROWS - 1), 1);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_row", 1, 0);
        else begin
          e_pop = exp_q.pop_front();
          chk("out_row", bus.out_row, e_pop.row);
          chk("out_data", bus.out_data, e_pop.data);
          last_row = bus.out_row;
        end
      end
    end else begin
      ov_prev = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic fill_const(input int av, input int wv);
    for (int i = 0; i < MAXK; i++) begin
      for (int r = 0; r < ROWS; r++) a_mat[i][r] = av;
      for (int c = 0; c < COLS; c++) b_mat[i][c] = wv;
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < MAXK; i++) begin
      for (int r = 0; r < ROWS; r++) a_mat[i][r] = int'($urandom_range(0, 255)) - 128;
      for (int c = 0; c < COLS; c++) b_mat[i][c] = int'($urandom_range(0, 255)) - 128;
    end
  endtask

  task automatic fill_ident();
    for (int i = 0; i < MAXK; i++) begin
      for (int r = 0; r < ROWS; r++) a_mat[i][r] = (i == r) ? 1 : 0;
      for (int c = 0; c < COLS; c++) b_mat[i][c] = i * COLS + c + 1;
    end
  endtask

  task automatic drive_beat(input int i);
    for (int r = 0; r < ROWS; r++) bus.act_in[r*BW_ACT +: BW_ACT] = BW_ACT'(a_mat[i][r]);
    for (int c = 0; c < COLS; c++) bus.wet_in[c*BW_WET +: BW_WET] = BW_WET'(b_mat[i][c]);
    bus.in_valid = 1'b1;
  endtask

  task automatic run(input int k, input int sh, input bit bubbles, input bit rnd_bubbles,
                     input bit start_mid, input bit bp);
    int d0, last_acc;
    for (int r = 0; r < ROWS; r++) exp_q.push_back('{r, model_row(r, k, sh)});
    d0 = done_cnt;
    first_ov = -1;
    bus.start = 1'b1;
    bus.k_len = BW_K'(k);
    bus.shift_num = 6'(sh);
    tick();
    bus.start = 1'b0;
    chk("busy_in_run", bus.busy, 1);
    for (int i = 0; i < k; i++) begin
      if (bubbles || (rnd_bubbles && $urandom_range(0, 1) == 1)) begin
        bus.in_valid = 1'b0;
        tick();
      end
      drive_beat(i);
      if (start_mid && i == 1) begin
        bus.start = 1'b1;
        bus.k_len = 8'd3;
        bus.shift_num = 6'd0;
      end
      chk("in_ready_feed", bus.in_ready, 1);
      tick();
      bus.start = 1'b0;
    end
    last_acc = cyc;
    bus.in_valid = 1'b0;
    chk("in_ready_after_last", bus.in_ready, 0);
    if (bp) begin
      for (int i = 0; i < 100 && !(bus.out_valid && bus.out_row == 1); i++) tick();
      chk("bp_reach_row1", longint'(bus.out_valid && bus.out_row == 1), 1);
      bus.out_ready = 1'b0;
      for (int j = 0; j < 3; j++) begin
        tick();
        chk("bp_hold_valid", bus.out_valid, 1);
        chk("bp_hold_row", bus.out_row, 1);
        chk("bp_hold_data", bus.out_data, model_row(1, k, sh));
      end
      bus.out_ready = 1'b1;
    end
    for (int i = 0; i < 400 && done_cnt == d0; i++) tick();
    tick();
    tick();
    chk("done_count", done_cnt - d0, 1);
    chk("latency", first_ov - last_acc, ROWS + COLS);
    chk("busy_idle", bus.busy, 0);
    chk("rows_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.k_len = '0;
    bus.shift_num = '0;
    bus.in_valid = 1'b0;
    bus.act_in = '0;
    bus.wet_in = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_row", bus.out_row, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    reset_n = 1'b1;
    tick();

    bus.start = 1'b1;
    bus.k_len = '0;
    tick();
    bus.start = 1'b0;
    tick();
    chk("klen0_busy", bus.busy, 0);
    chk("klen0_in_ready", bus.in_ready, 0);

    fill_const(2, 3);
    run(1, 0, 0, 0, 0, 0);
    fill_ident();
    run(4, 0, 0, 0, 0, 0);
    run(4, 0, 1, 0, 0, 0);
    fill_const(127, 127);
    run(4, 0, 0, 0, 0, 0);
    run(4, 9, 0, 0, 0, 0);
    fill_const(-128, 127);
    run(4, 0, 0, 0, 0, 0);
    fill_ident();
    run(4, 0, 0, 0, 0, 1);
    fill_rand();
    run(6, 4, 0, 0, 1, 0);

    fill_rand();
    bus.start = 1'b1;
    bus.k_len = 8'd8;
    bus.shift_num = 6'd0;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_beat(i);
      tick();
    end
    #2 reset_n = 1'b0;
    #1;
    bus.in_valid = 1'b0;
    chk("abort_in_ready", bus.in_ready, 0);
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_out_data", bus.out_data, 0);
    chk("abort_out_row", bus.out_row, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    #14 reset_n = 1'b1;
    tick();
    fill_const(2, 3);
    run(1, 0, 0, 0, 0, 0);

    for (int n = 0; n < 20; n++) begin
      int k, sh;
      k = $urandom_range(1, MAXK);
      sh = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 12);
      fill_rand();
      rand_ready = 1'($urandom_range(0, 1));
      run(k, sh, 0, 1, 0, 0);
      rand_ready = 1'b0;
      tick();
      tick();
      bus.out_ready = 1'b1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
